// File: rtl/bpsk_demod_text.sv
// Integrate-and-dump BPSK demodulator: sums SPS soft samples per symbol, slices on the
// accumulator sign, and packs N decisions LSB-first into a valid/ready word.
module bpsk_demod_text #(
    parameter int N   = 12,
    parameter int SPS = 4,
    parameter int SW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sym_clr,
    input  logic [SW-1:0] in_sample,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  data_out,
    output logic          tie_flag,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int AW = SW + $clog2(SPS) + 1;
    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int BW = $clog2(N + 1);

    function automatic logic signed [AW-1:0] sext(input logic [SW-1:0] s);
        return {{(AW-SW){s[SW-1]}}, s};
    endfunction

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic [CW-1:0]        samp_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [N-1:0]         shreg;
    logic                 tie_acc;

    logic                 last_samp;
    logic                 last_bit;
    logic                 accept;
    logic                 dbit;
    logic                 tie;
    logic                 word_done;
    logic [N-1:0]         next_word;

    assign last_samp = (samp_cnt == CW'(SPS - 1));
    assign last_bit  = (bit_cnt == BW'(N - 1));
    assign in_ready  = !(out_valid && !out_ready && last_bit && last_samp);
    // A sample coinciding with sym_clr is dropped, not integrated.
    assign accept    = in_valid && in_ready && !sym_clr;

    assign sum       = acc + sext(in_sample);
    assign dbit      = sum[AW-1];
    assign tie       = (sum == '0);
    assign word_done = accept && last_samp && last_bit;
    assign next_word = shreg | ({{(N-1){1'b0}}, dbit} << bit_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            tie_acc   <= 1'b0;
            data_out  <= '0;
            tie_flag  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (sym_clr) begin
                acc      <= '0;
                samp_cnt <= '0;
                bit_cnt  <= '0;
                shreg    <= '0;
                tie_acc  <= 1'b0;
            end else if (accept) begin
                if (last_samp) begin
                    acc      <= '0;
                    samp_cnt <= '0;
                    if (last_bit) begin
                        bit_cnt  <= '0;
                        shreg    <= '0;
                        tie_acc  <= 1'b0;
                        data_out <= next_word;
                        tie_flag <= tie_acc | tie;
                    end else begin
                        bit_cnt  <= bit_cnt + BW'(1);
                        shreg    <= next_word;
                        tie_acc  <= tie_acc | tie;
                    end
                end else begin
                    acc      <= sum;
                    samp_cnt <= samp_cnt + CW'(1);
                end
            end

            // A completing word wins over consumption of the previous one.
            if (word_done)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bpsk_demod_text.sv
// Directed bench for bpsk_demod_text: table of whole words plus hand-built sequences
// for backpressure, sym_clr and asynchronous reset.
module tb_bpsk_demod_text;

    logic        clk = 1'b0;
    logic        rst;
    logic        sym_clr;
    logic [1:0]  in_sample;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] data_out;
    logic        tie_flag;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    bpsk_demod_text #(.N(12), .SPS(4), .SW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_clr   (sym_clr),
        .in_sample (in_sample),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .tie_flag  (tie_flag),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] word;
        bit          noisy;
        int          tie_pos;
        logic [11:0] exp_data;
        logic        exp_tie;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] samp_of(input logic [11:0] word, input bit noisy,
                                           input int tie_pos, input int k);
        int b;
        int j;
        logic [1:0] s;
        b = k / 4;
        j = k % 4;
        if (b == tie_pos) begin
            s = (j % 2 == 0) ? 2'b01 : 2'b11;
        end else if (noisy) begin
            if (word[b]) s = (j == 2) ? 2'b01 : 2'b11;
            else         s = (j == 2) ? 2'b11 : 2'b01;
        end else begin
            s = word[b] ? 2'b11 : 2'b01;
        end
        return s;
    endfunction

    // Presents one sample and returns 1 ns after the edge that accepted it.
    task automatic send_sample(input logic [1:0] s);
        int t;
        in_sample = s;
        in_valid  = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t == 100) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_range(input logic [11:0] word, input bit noisy, input int tie_pos,
                              input int from, input int upto);
        for (int k = from; k < upto; k++)
            send_sample(samp_of(word, noisy, tie_pos, k));
    endtask

    initial begin
        vecs[0] = '{word: 12'hA53, noisy: 1'b0, tie_pos: -1, exp_data: 12'hA53, exp_tie: 1'b0};
        vecs[1] = '{word: 12'h002, noisy: 1'b1, tie_pos: -1, exp_data: 12'h002, exp_tie: 1'b0};
        vecs[2] = '{word: 12'h000, noisy: 1'b0, tie_pos: 5,  exp_data: 12'h000, exp_tie: 1'b1};
        vecs[3] = '{word: 12'h000, noisy: 1'b0, tie_pos: -1, exp_data: 12'h000, exp_tie: 1'b0};
        vecs[4] = '{word: 12'hFFF, noisy: 1'b1, tie_pos: -1, exp_data: 12'hFFF, exp_tie: 1'b0};
        vecs[5] = '{word: 12'h800, noisy: 1'b0, tie_pos: 11, exp_data: 12'h000, exp_tie: 1'b1};

        rst       = 1'b1;
        sym_clr   = 1'b0;
        in_sample = 2'b00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_tie_flag", 32'(tie_flag), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            send_range(vecs[v].word, vecs[v].noisy, vecs[v].tie_pos, 0, 47);
            chk($sformatf("vec%0d_valid_early", v), 32'(out_valid), 32'd0);
            send_range(vecs[v].word, vecs[v].noisy, vecs[v].tie_pos, 47, 48);
            chk($sformatf("vec%0d_valid", v), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_data", v), 32'(data_out), 32'(vecs[v].exp_data));
            chk($sformatf("vec%0d_tie", v), 32'(tie_flag), 32'(vecs[v].exp_tie));
            @(posedge clk);
            #1;
        end

        // Backpressure: two words back to back with the sink stalled.
        out_ready = 1'b0;
        send_range(12'h0F0, 1'b0, -1, 0, 48);
        chk("bp_w1_valid", 32'(out_valid), 32'd1);
        chk("bp_w1_data", 32'(data_out), 32'h0F0);
        send_range(12'h30C, 1'b0, -1, 0, 46);
        chk("bp_ready_before", 32'(in_ready), 32'd1);
        send_range(12'h30C, 1'b0, -1, 46, 47);
        chk("bp_ready_drop", 32'(in_ready), 32'd0);
        in_sample = samp_of(12'h30C, 1'b0, -1, 47);
        in_valid  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_held", 32'(in_ready), 32'd0);
        chk("bp_hold_data", 32'(data_out), 32'h0F0);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_w2_valid", 32'(out_valid), 32'd1);
        chk("bp_w2_data", 32'(data_out), 32'h30C);
        @(posedge clk);
        #1;
        chk("bp_w2_consumed", 32'(out_valid), 32'd0);

        // sym_clr with a coincident sample after a partial word.
        send_range(12'hFFF, 1'b0, -1, 0, 17);
        in_sample = 2'b11;
        in_valid  = 1'b1;
        sym_clr   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sym_clr  = 1'b0;
        chk("clr_no_valid", 32'(out_valid), 32'd0);
        send_range(12'h555, 1'b0, -1, 0, 47);
        chk("clr_valid_early", 32'(out_valid), 32'd0);
        send_range(12'h555, 1'b0, -1, 47, 48);
        chk("clr_valid", 32'(out_valid), 32'd1);
        chk("clr_data", 32'(data_out), 32'h555);
        @(posedge clk);
        #1;

        // Asynchronous reset while a word is pending and another is half built.
        out_ready = 1'b0;
        send_range(12'hABC, 1'b0, -1, 0, 48);
        chk("rst_pre_data", 32'(data_out), 32'hABC);
        send_range(12'h123, 1'b0, -1, 0, 10);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_data", 32'(data_out), 32'd0);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send_range(12'hFFF, 1'b0, -1, 0, 47);
        chk("rst_next_early", 32'(out_valid), 32'd0);
        send_range(12'hFFF, 1'b0, -1, 47, 48);
        chk("rst_next_valid", 32'(out_valid), 32'd1);
        chk("rst_next_data", 32'(data_out), 32'hFFF);
        chk("rst_next_tie", 32'(tie_flag), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpsk_demod_text.md
Name: bpsk_demod_text

Overview:
- Receive-side counterpart of the text-path BPSK modulator. It recovers the original N-bit word from a stream of signed soft samples.
- Samples follow the modulator's 2-bit mapping: bit 0 = +1 (2'b01), bit 1 = -1 (2'b11). The modulator emits bit 0 first, at the LSB of its output.
- Each symbol spans SPS samples. The block integrates them (integrate-and-dump), makes a hard sign decision per symbol, and assembles N decisions LSB-first.
- The finished word is presented on a valid/ready output toward the Hamming/BCH decoder.

Parameters:
- N, 12, bits per word: 12 for Hamming, 15 for BCH.
- SPS, 4, samples per symbol. Must be >= 1.
- SW, 2, soft sample width, two's complement.
- AW, SW+$clog2(SPS)+1, accumulator width. Derived; not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- sym_clr  input  1  synchronous framing restart: clears the accumulator and counters.
- in_sample  input  SW  signed soft sample.
- in_valid  input  1  in_sample is valid.
- in_ready  output  1  block accepts in_sample this cycle.
- data_out  output  N  recovered word; bit 0 is the first symbol received.
- tie_flag  output  1  at least one symbol in data_out had an accumulator sum of exactly 0.
- out_valid  output  1  data_out and tie_flag are valid.
- out_ready  input  1  downstream consumes the word.

Behaviour:
- Reset (async, rst=1):
  - acc=0, samp_cnt=0, bit_cnt=0, shift register=0, tie accumulator=0.
  - data_out=0, tie_flag=0, out_valid=0.
  - in_ready=1 once rst is released.
- Sample accept: a sample is accepted when in_valid && in_ready at a rising edge.
- Integration, on each accepted sample:
  - The sample is sign-extended to AW and added to acc.
  - samp_cnt counts 0..SPS-1.
- Decision, on the accepted sample with samp_cnt==SPS-1:
  - sum = acc + sample.
  - Decided bit = 1 if sum < 0, else 0. A tie (sum == 0) decides 0 and sets the word's tie bit.
  - The decided bit is written to shift-register position bit_cnt (LSB-first fill).
  - acc and samp_cnt clear; bit_cnt increments.
- Word complete: on the decision with bit_cnt==N-1:
  - The next cycle, data_out gets the full word, tie_flag gets the accumulated tie state, and out_valid=1.
  - Latency is 1 cycle from the last accepted sample.
  - bit_cnt, the shift register and the tie accumulator clear in the same edge. Assembly of the next word continues with no gap.
- Output hold rules:
  - out_valid clears on out_valid && out_ready, unless a new word completes in the same cycle; in that case out_valid stays 1 with the new data.
  - data_out and tie_flag are stable while out_valid && !out_ready.
- Backpressure:
  - in_ready = !(out_valid && !out_ready && bit_cnt==N-1 && samp_cnt==SPS-1).
  - Input stalls only when the next sample would complete a word while the previous word is still unconsumed. No word is ever overwritten or dropped.
- sym_clr:
  - Clears acc, samp_cnt, bit_cnt, the shift register and the tie accumulator.
  - A sample presented in the same cycle is discarded and counted nowhere.
  - Does not touch data_out, tie_flag or out_valid: a pending word stays valid.
- Arithmetic:
  - AW bits cannot overflow: SPS samples of magnitude <= 2^(SW-1) fit.
  - The accumulator sign bit is the decision.
- Reset mid-word: all partial state is lost and out_valid drops immediately (async).
- The FSM is implicit in the counters:
  - ACC: integrating, bit_cnt<N.
  - STALL: in_ready=0 in the condition above; returns to ACC on out_ready.

Test Plan:
- N=12, SPS=4, SW=2, out_ready=1. Feed word 0x A53 as 48 clean samples, LSB first: 11 for bit=1, 01 for bit=0, 4 per bit. -> out_valid pulses 1 cycle after sample 48; data_out=12'hA53; tie_flag=0.
- Noisy symbols: for bit 0, samples {01,01,11,01} (sum +2) -> decided 0. For bit 1, samples {11,11,01,11} (sum -2) -> decided 1. -> data_out=12'h002, tie_flag=0.
- Tie: bit 5 fed {01,11,01,11} (sum 0), all other bits clean 0 -> data_out=12'h000, tie_flag=1. The next clean word has tie_flag=0.
- Backpressure: out_ready=0; stream two back-to-back words 12'h0F0 and 12'h30C.
  - in_ready must drop exactly at sample 48 of word 2.
  - data_out holds 12'h0F0.
  - Raise out_ready -> 12'h0F0 consumed, 12'h30C appears 1 cycle after the stalled sample is accepted.
- sym_clr: after 17 samples of a word, assert sym_clr together with in_valid. Then feed a clean 12'h555 -> data_out=12'h555. The discarded sample has no effect.
- Async rst asserted mid-word while out_valid=1 -> out_valid=0 and data_out=0 immediately, without a clock edge. Next clean word 12'hFFF decodes correctly.
